intersection_phase_arbiter: RTL and testbench



---
 rtl/traffic_pkg.sv | 27 ++
 rtl/rr_next_picker.sv | 25 ++
 rtl/intersection_phase_arbiter.sv | 144 ++++++++++++++
 tb/tb_intersection_phase_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light codes, phase encoding and lights packing helper
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b11;

  // Widest intersection any arbiter in this family supports.
  localparam int MAX_APPR = 8;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_t;

  // Place one approach's code into an otherwise all-red lights vector.
  function automatic logic [2*MAX_APPR-1:0] pack_light(input int id, input logic [1:0] code);
    logic [2*MAX_APPR-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_APPR; i++) begin
      if (i == id) v[2*i +: 2] = code;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_next_picker.sv
// rtl/rr_next_picker.sv - round-robin pick of the next pending approach after the current owner
module rr_next_picker #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   pending,
  input  logic [IDW-1:0] active_id,
  output logic [IDW-1:0] next_id,
  output logic           valid
);

  int idx;

  // Scan from farthest to nearest so the nearest set bit after active_id wins; active_id itself is last.
  always_comb begin
    next_id = active_id;
    valid   = |pending;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(active_id) + k) % N;
      if (pending[idx[IDW-1:0]]) next_id = idx[IDW-1:0];
    end
  end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// rtl/intersection_phase_arbiter.sv - round-robin green/yellow/all-red phase arbiter for one intersection
module intersection_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int N_APPR     = 4,
  parameter int MIN_GREEN  = 3,
  parameter int MAX_GREEN  = 6,
  parameter int YELLOW_CYC = 1,
  parameter int ALLRED_CYC = 1,
  parameter int TW         = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_APPR-1:0]         car,
  output logic [2*N_APPR-1:0]       lights,
  output logic [$clog2(N_APPR)-1:0] active_id,
  output logic [1:0]                phase,
  output logic                      grant_pulse,
  output logic [N_APPR-1:0]         pending
);

  localparam int IDW = $clog2(N_APPR);
  localparam int LW  = 2 * N_APPR;

  phase_t              state;
  logic [TW-1:0]       timer;
  logic [TW:0]         t_next;
  logic [N_APPR-1:0]   own_mask;
  logic [N_APPR-1:0]   req_set;
  logic [N_APPR-1:0]   next_mask;
  logic                other_req;
  logic                go_yellow;
  logic                yellow_done;
  logic                allred_done;
  logic [IDW-1:0]      next_id;
  logic                next_valid;
  logic [LW-1:0]       lights_reset;
  logic [LW-1:0]       lights_yellow;
  logic [LW-1:0]       lights_grant;
  int                  nonred;

  rr_next_picker #(
    .N   (N_APPR),
    .IDW (IDW)
  ) u_picker (
    .pending   (pending),
    .active_id (active_id),
    .next_id   (next_id),
    .valid     (next_valid)
  );

  // One extra timer bit so timer+1 never wraps before being compared.
  assign t_next    = {1'b0, timer} + 1'b1;
  assign own_mask  = N_APPR'(1) << active_id;
  assign next_mask = N_APPR'(1) << next_id;

  // The green owner's own detector is ignored; it is already being served.
  assign req_set   = car & ~((state == PH_GREEN) ? own_mask : '0);
  assign other_req = |(pending & ~own_mask);

  // Leave green only when someone else waits, after the minimum, and when the owner is idle or out of time.
  assign go_yellow   = (state == PH_GREEN) && (t_next >= (TW+1)'(MIN_GREEN)) && other_req &&
                       (!car[active_id] || (t_next >= (TW+1)'(MAX_GREEN)));
  assign yellow_done = (t_next == (TW+1)'(YELLOW_CYC));
  assign allred_done = (t_next == (TW+1)'(ALLRED_CYC));

  assign lights_reset  = LW'(pack_light(0, LIGHT_GREEN));
  assign lights_yellow = LW'(pack_light(int'(active_id), LIGHT_YELLOW));
  assign lights_grant  = LW'(pack_light(int'(next_id), LIGHT_GREEN));

  assign phase = state;

  // Phase sequencer: all outputs registered, request latching runs every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PH_GREEN;
      active_id   <= '0;
      timer       <= '0;
      pending     <= '0;
      grant_pulse <= 1'b0;
      lights      <= lights_reset;
    end else begin
      grant_pulse <= 1'b0;
      pending     <= pending | req_set;
      case (state)
        PH_GREEN: begin
          if (go_yellow) begin
            state  <= PH_YELLOW;
            timer  <= '0;
            lights <= lights_yellow;
          end else if (t_next >= (TW+1)'(MAX_GREEN)) begin
            timer <= TW'(MAX_GREEN);
          end else begin
            timer <= t_next[TW-1:0];
          end
        end
        PH_YELLOW: begin
          if (yellow_done) begin
            state  <= PH_ALLRED;
            timer  <= '0;
            lights <= '0;
          end else begin
            timer <= t_next[TW-1:0];
          end
        end
        PH_ALLRED: begin
          if (allred_done) begin
            // With nothing pending the picker returns active_id, so the owner simply keeps the road.
            state       <= PH_GREEN;
            timer       <= '0;
            active_id   <= next_id;
            pending     <= (pending | req_set) & ~next_mask;
            grant_pulse <= 1'b1;
            lights      <= lights_grant;
          end else begin
            timer <= t_next[TW-1:0];
          end
        end
        default: begin
          state  <= PH_GREEN;
          timer  <= '0;
          lights <= lights_reset;
        end
      endcase
    end
  end

  // Count approaches showing anything other than red.
  always_comb begin
    nonred = 0;
    for (int i = 0; i < N_APPR; i++) begin
      if (lights[2*i +: 2] != LIGHT_RED) nonred = nonred + 1;
    end
  end

  // Safety: never more than one approach off red.
  always_ff @(posedge clk) begin
    if (!reset) assert (nonred <= 1);
  end

  logic unused_ok;
  assign unused_ok = next_valid;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb/tb_intersection_phase_arbiter.sv - randomized and directed bench with behavioural intersection model
module tb_intersection_phase_arbiter;

  localparam int N   = 4;
  localparam int MIN = 3;
  localparam int MAX = 6;
  localparam int YEL = 1;
  localparam int AR  = 1;

  logic           clk;
  logic           reset;
  logic [N-1:0]   car;
  logic [2*N-1:0] lights;
  logic [1:0]     active_id;
  logic [1:0]     phase;
  logic           grant_pulse;
  logic [N-1:0]   pending;

  intersection_phase_arbiter #(
    .N_APPR     (N),
    .MIN_GREEN  (MIN),
    .MAX_GREEN  (MAX),
    .YELLOW_CYC (YEL),
    .ALLRED_CYC (AR),
    .TW         (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .car         (car),
    .lights      (lights),
    .active_id   (active_id),
    .phase       (phase),
    .grant_pulse (grant_pulse),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 green / 1 yellow / 2 all-red, owner, cycles spent in phase, waiting set.
  int           m_ph;
  int           m_act;
  int           m_age;
  logic [N-1:0] m_pend;
  bit           m_gnt;
  bit           m_ready = 0;
  int           gq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] c);
    logic [N-1:0] np;
    bit other;
    bit found;
    int nxt;
    if (r) begin
      m_ph = 0; m_act = 0; m_age = 0; m_pend = '0; m_gnt = 0; m_ready = 1;
      return;
    end
    other = 0;
    for (int j = 0; j < N; j++) if (j != m_act && m_pend[j]) other = 1;
    np = m_pend;
    for (int j = 0; j < N; j++) if (c[j] && !(m_ph == 0 && j == m_act)) np[j] = 1'b1;
    m_gnt = 0;
    if (m_ph == 0) begin
      if (m_age + 1 >= MIN && other && (!c[m_act] || m_age + 1 >= MAX)) begin
        m_ph = 1; m_age = 0;
      end else begin
        m_age = (m_age + 1 > MAX) ? MAX : m_age + 1;
      end
    end else if (m_ph == 1) begin
      if (m_age + 1 == YEL) begin m_ph = 2; m_age = 0; end
      else m_age++;
    end else begin
      if (m_age + 1 == AR) begin
        found = 0;
        nxt = m_act;
        for (int k = 1; k <= N; k++) begin
          if (!found && m_pend[(m_act + k) % N]) begin
            nxt = (m_act + k) % N;
            found = 1;
          end
        end
        m_act = nxt;
        np[nxt] = 1'b0;
        m_gnt = 1;
        m_ph = 0;
        m_age = 0;
      end else begin
        m_age++;
      end
    end
    m_pend = np;
  endtask

  task automatic compare();
    logic [2*N-1:0] el;
    int cnt;
    el = '0;
    if (m_ph == 0) el[2*m_act +: 2] = 2'b11;
    else if (m_ph == 1) el[2*m_act +: 2] = 2'b01;
    check("lights", 32'(lights), 32'(el));
    check("phase", 32'(phase), 32'(m_ph));
    check("active_id", 32'(active_id), 32'(m_act));
    check("grant_pulse", 32'(grant_pulse), 32'(m_gnt));
    check("pending", 32'(pending), 32'(m_pend));
    cnt = 0;
    for (int i = 0; i < N; i++) if (lights[2*i +: 2] != 2'b00) cnt++;
    check("one_nonred", 32'(cnt <= 1), 32'd1);
  endtask

  task automatic tick(input logic r, input logic [N-1:0] c);
    @(negedge clk);
    reset = r;
    car   = c;
    @(posedge clk);
    model_step(r, c);
    #1;
    if (m_ready) compare();
    if (grant_pulse === 1'b1) gq.push_back(int'(active_id));
  endtask

  int cnt0;
  int g0, g1;
  bit reached;
  logic [N-1:0] rc;

  initial begin
    reset = 1'b1;
    car   = '0;

    // Idle after reset: approach 0 keeps green, nothing granted.
    tick(1'b1, '0);
    gq.delete();
    repeat (20) tick(1'b0, '0);
    check("t1_lights", 32'(lights), 32'h03);
    check("t1_phase", 32'(phase), 32'h0);
    check("t1_active", 32'(active_id), 32'h0);
    check("t1_no_grant", 32'(gq.size()), 32'd0);

    // Single pulse on approach 2.
    tick(1'b1, '0);
    tick(1'b0, 4'b0100);
    check("t2_pend", 32'(pending), 32'h4);
    check("t2_green2", 32'(lights), 32'h03);
    tick(1'b0, '0);
    check("t2_green3", 32'(lights), 32'h03);
    tick(1'b0, '0);
    check("t2_yellow", 32'(lights), 32'h01);
    tick(1'b0, '0);
    check("t2_allred", 32'(lights), 32'h00);
    tick(1'b0, '0);
    check("t2_lights", 32'(lights), 32'h30);
    check("t2_active", 32'(active_id), 32'h2);
    check("t2_grant", 32'(grant_pulse), 32'h1);
    check("t2_pend0", 32'(pending), 32'h0);
    tick(1'b0, '0);
    check("t2_grant_off", 32'(grant_pulse), 32'h0);

    // Approach 0 and 1 held: 0 runs to the maximum green.
    tick(1'b1, '0);
    gq.delete();
    cnt0 = (phase == 2'b00 && active_id == 2'd0) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 4'b0011);
      if (gq.size() == 0 && phase == 2'b00 && active_id == 2'd0) cnt0++;
    end
    check("t3_green_len", 32'(cnt0), 32'd6);
    g0 = (gq.size() > 0) ? gq[0] : 99;
    check("t3_first_grant", 32'(g0), 32'd1);

    // Approaches 1 and 3 together: order 1 then 3, then 3 holds.
    tick(1'b1, '0);
    gq.delete();
    tick(1'b0, 4'b1010);
    repeat (30) tick(1'b0, '0);
    g0 = (gq.size() > 0) ? gq[0] : 99;
    g1 = (gq.size() > 1) ? gq[1] : 99;
    check("t4_ngrants", 32'(gq.size()), 32'd2);
    check("t4_g0", 32'(g0), 32'd1);
    check("t4_g1", 32'(g1), 32'd3);
    check("t4_hold3", 32'(lights), 32'hC0);

    // From owner 3, pending 0 and 2: wrap to 0 then 2.
    gq.delete();
    tick(1'b0, 4'b0101);
    check("t5_pend", 32'(pending), 32'h5);
    repeat (30) tick(1'b0, '0);
    g0 = (gq.size() > 0) ? gq[0] : 99;
    g1 = (gq.size() > 1) ? gq[1] : 99;
    check("t5_g0", 32'(g0), 32'd0);
    check("t5_g1", 32'(g1), 32'd2);
    check("t5_active", 32'(active_id), 32'd2);

    // Reset during yellow.
    tick(1'b1, '0);
    tick(1'b0, 4'b0110);
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      tick(1'b0, '0);
      if (phase == 2'b01) reached = 1;
    end
    check("t6_reached_yellow", 32'(reached), 32'd1);
    check("t6_pend_before", 32'(pending), 32'h6);
    tick(1'b1, '0);
    check("t6_phase", 32'(phase), 32'h0);
    check("t6_active", 32'(active_id), 32'h0);
    check("t6_lights", 32'(lights), 32'h03);
    check("t6_pend", 32'(pending), 32'h0);
    check("t6_grant", 32'(grant_pulse), 32'h0);

    // Randomized traffic with occasional resets.
    rc = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rc = N'($urandom);
      if ($urandom_range(0, 5) == 0) rc = '0;
      tick(($urandom_range(0, 299) == 0), rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
